// File: rtl/bcd_updown_counter_7seg_pkg.sv
// Purpose: shared constants and helpers for the BCD up/down counter with
//          7-segment decode.
// Contents: digit / segment widths, segment patterns {a,b,c,d,e,f,g}
//           (a is the MSB), and bcd_to_seg() decoder.
package bcd7seg_pkg;

    localparam int DIG_W = 4;
    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;

    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [DIG_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_7seg_if.sv
// Purpose: control/status bundle of the BCD up/down counter.
// Signals: clr, load, load_val, en, up (controls, driven by master);
//          bcd, seg, wrap, sat, load_err (status, driven by slave/counter).
interface bcd_updown_counter_7seg_if #(
    parameter int NDIG = 3
);
    logic              clr;
    logic              load;
    logic [4*NDIG-1:0] load_val;
    logic              en;
    logic              up;
    logic [4*NDIG-1:0] bcd;
    logic [7*NDIG-1:0] seg;
    logic              wrap;
    logic              sat;
    logic              load_err;

    modport master (
        output clr, load, load_val, en, up,
        input  bcd, seg, wrap, sat, load_err
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output bcd, seg, wrap, sat, load_err
    );
endinterface

// File: rtl/bcd_updown_counter_7seg_digit.sv
// Purpose: one decade register of the BCD counter.
// Ports: clk, rstn (async active-low), clr, load, ld_val (out-of-range loads
//        become 0), step (advance this cycle), up (direction);
//        q (digit), at_max (q==9), at_min (q==0).
module bcd_digit
    import bcd7seg_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [DIG_W-1:0] ld_val,
    input  logic             step,
    input  logic             up,
    output logic [DIG_W-1:0] q,
    output logic             at_max,
    output logic             at_min
);
    logic [DIG_W-1:0] q_d;
    logic [DIG_W-1:0] q_q;

    assign at_max = (q_q == 4'd9);
    assign at_min = (q_q == 4'd0);
    assign q      = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = (ld_val > 4'd9) ? 4'd0 : ld_val;
        end else if (step) begin
            if (up) begin
                q_d = at_max ? 4'd0 : q_q + 4'd1;
            end else begin
                q_d = at_min ? 4'd9 : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end
endmodule

// File: rtl/bcd_updown_counter_7seg.sv
// Purpose: NDIG-digit BCD up/down counter with per-digit 7-segment outputs.
// Ports: clk, rstn (async active-low), bus (slave side of the counter
//        interface: clr > load > en controls in, bcd/seg/wrap/sat/load_err out).
// Parameters: NDIG digits, SATURATE (hold at limits), BLANK_LZ (blank leading
//             zeros), SEG_ACT_LOW (invert segments).
module bcd_updown_counter_7seg
    import bcd7seg_pkg::*;
#(
    parameter int NDIG        = 3,
    parameter int SATURATE    = 0,
    parameter int BLANK_LZ    = 0,
    parameter int SEG_ACT_LOW = 0
) (
    input  logic                            clk,
    input  logic                            rstn,
    bcd_updown_counter_7seg_if.slave        bus
);
    logic [NDIG-1:0]  at_max;
    logic [NDIG-1:0]  at_min;
    logic [NDIG-1:0]  step;
    logic [DIG_W-1:0] q [NDIG];

    logic all_max, all_min, count_act, at_limit, blocked, step_en;
    logic wrap_d, wrap_q, sat_d, sat_q, load_err_d, load_err_q;
    logic bad_digit;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rstn   (rstn),
            .clr    (bus.clr),
            .load   (bus.load),
            .ld_val (bus.load_val[DIG_W*g +: DIG_W]),
            .step   (step[g]),
            .up     (bus.up),
            .q      (q[g]),
            .at_max (at_max[g]),
            .at_min (at_min[g])
        );
        assign bus.bcd[DIG_W*g +: DIG_W] = q[g];
    end

    assign all_max   = &at_max;
    assign all_min   = &at_min;
    assign count_act = bus.en & ~bus.clr & ~bus.load;
    assign at_limit  = bus.up ? all_max : all_min;
    assign blocked   = count_act & at_limit & (SATURATE != 0);
    assign step_en   = count_act & ~blocked;

    // Ripple-free step: every digit sees the whole lower carry/borrow chain
    // in the same cycle, so all decades advance together.
    always_comb begin
        logic chain_max;
        logic chain_min;
        step      = '0;
        chain_max = 1'b1;
        chain_min = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            step[i]   = step_en & (bus.up ? chain_max : chain_min);
            chain_max = chain_max & at_max[i];
            chain_min = chain_min & at_min[i];
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.load_val[DIG_W*i +: DIG_W] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
        load_err_d = ~bus.clr & bus.load & bad_digit;
        wrap_d     = count_act & at_limit & (SATURATE == 0);
        sat_d      = blocked;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            sat_q      <= sat_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.wrap     = wrap_q;
    assign bus.sat      = sat_q;
    assign bus.load_err = load_err_q;

    // Leading-zero detect runs from the most significant digit downward;
    // digit 0 is always shown.
    always_comb begin
        logic             hi_zero;
        logic [SEG_W-1:0] raw;
        bus.seg = '0;
        hi_zero = 1'b1;
        raw     = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            hi_zero = hi_zero & at_min[i];
            raw     = (BLANK_LZ != 0 && i > 0 && hi_zero) ? SEG_BLANK : bcd_to_seg(q[i]);
            bus.seg[SEG_W*i +: SEG_W] = (SEG_ACT_LOW != 0) ? ~raw : raw;
        end
    end
endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
module tb_bcd_updown_counter_7seg;

    typedef struct packed {
        int v;
        bit w;
        bit s;
        bit le;
    } res_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    res_t ma, mb, mc;

    always #5 clk = ~clk;

    bcd_updown_counter_7seg_if #(.NDIG(3)) ifa ();
    bcd_updown_counter_7seg_if #(.NDIG(3)) ifb ();
    bcd_updown_counter_7seg_if #(.NDIG(3)) ifc ();

    bcd_updown_counter_7seg #(.NDIG(3), .SATURATE(0), .BLANK_LZ(0), .SEG_ACT_LOW(0))
        dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
    bcd_updown_counter_7seg #(.NDIG(3), .SATURATE(1), .BLANK_LZ(0), .SEG_ACT_LOW(0))
        dut_b (.clk(clk), .rstn(rstn), .bus(ifb));
    bcd_updown_counter_7seg #(.NDIG(3), .SATURATE(0), .BLANK_LZ(1), .SEG_ACT_LOW(1))
        dut_c (.clk(clk), .rstn(rstn), .bus(ifc));

    logic [35:0] obs_a, obs_b, obs_c;
    assign obs_a = {ifa.bcd, ifa.seg, ifa.wrap, ifa.sat, ifa.load_err};
    assign obs_b = {ifb.bcd, ifb.seg, ifb.wrap, ifb.sat, ifb.load_err};
    assign obs_c = {ifc.bcd, ifc.seg, ifc.wrap, ifc.sat, ifc.load_err};

    // Reference model: the count is held as a plain integer 0..999.
    function automatic res_t model(res_t cur, bit clr, bit load, logic [11:0] lv,
                                   bit en, bit up, bit satm);
        res_t r;
        int   d;
        r    = cur;
        r.w  = 1'b0;
        r.s  = 1'b0;
        r.le = 1'b0;
        if (clr) begin
            r.v = 0;
        end else if (load) begin
            r.v = 0;
            for (int i = 2; i >= 0; i--) begin
                d = int'(lv[4*i +: 4]);
                if (d > 9) begin
                    r.le = 1'b1;
                    d    = 0;
                end
                r.v = r.v * 10 + d;
            end
        end else if (en && up) begin
            if (cur.v == 999) begin
                if (satm) r.s = 1'b1;
                else begin r.v = 0; r.w = 1'b1; end
            end else r.v = cur.v + 1;
        end else if (en) begin
            if (cur.v == 0) begin
                if (satm) r.s = 1'b1;
                else begin r.v = 999; r.w = 1'b1; end
            end else r.v = cur.v - 1;
        end
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(int v);
        logic [11:0] b;
        b[3:0]  = 4'(v % 10);
        b[7:4]  = 4'((v / 10) % 10);
        b[11:8] = 4'((v / 100) % 10);
        return b;
    endfunction

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b1001111;
        endcase
    endfunction

    function automatic logic [20:0] exp_seg(int v, bit blz, bit inv);
        logic [20:0] s;
        logic [6:0]  raw;
        int          p;
        s = '0;
        p = 1;
        for (int i = 0; i < 3; i++) begin
            raw = (blz && i > 0 && v < p) ? 7'b0000000 : seg_of((v / p) % 10);
            s[7*i +: 7] = inv ? ~raw : raw;
            p = p * 10;
        end
        return s;
    endfunction

    function automatic logic [35:0] exp_vec(res_t r, bit blz, bit inv);
        return {to_bcd(r.v), exp_seg(r.v, blz, inv), r.w, r.s, r.le};
    endfunction

    task automatic drive_cycle(input bit c, input bit l, input logic [11:0] lv,
                               input bit e, input bit u);
        ifa.clr = c; ifa.load = l; ifa.load_val = lv; ifa.en = e; ifa.up = u;
        ifb.clr = c; ifb.load = l; ifb.load_val = lv; ifb.en = e; ifb.up = u;
        ifc.clr = c; ifc.load = l; ifc.load_val = lv; ifc.en = e; ifc.up = u;
        @(posedge clk);
        #1;
        ma = model(ma, c, l, lv, e, u, 1'b0);
        mb = model(mb, c, l, lv, e, u, 1'b1);
        mc = model(mc, c, l, lv, e, u, 1'b0);
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b1, 12'h789, 1'b1, 1'b1);
        ma = '0; mb = '0; mc = '0;
        tests++;
        if (obs_a !== exp_vec(ma, 1'b0, 1'b0)) begin
            fails++; $display("FAIL reset_a: got %h expected %h", obs_a, exp_vec(ma, 1'b0, 1'b0));
        end
        tests++;
        if (obs_b !== exp_vec(mb, 1'b0, 1'b0)) begin
            fails++; $display("FAIL reset_b: got %h expected %h", obs_b, exp_vec(mb, 1'b0, 1'b0));
        end
        tests++;
        if (ifc.seg !== 21'b1111111_1111111_0000001) begin
            fails++; $display("FAIL reset_c_seg: got %b expected %b", ifc.seg, 21'b1111111_1111111_0000001);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_count_up();
        int wraps;
        wraps = 0;
        drive_cycle(1'b1, 1'b0, 12'h0, 1'b0, 1'b1);
        for (int n = 1; n <= 1000; n++) begin
            drive_cycle(1'b0, 1'b0, 12'h0, 1'b1, 1'b1);
            if (ifa.wrap === 1'b1) wraps++;
            tests++;
            if (obs_a !== exp_vec(ma, 1'b0, 1'b0)) begin
                fails++; $display("FAIL up_a step %0d: got %h expected %h", n, obs_a, exp_vec(ma, 1'b0, 1'b0));
            end
            tests++;
            if (obs_b !== exp_vec(mb, 1'b0, 1'b0)) begin
                fails++; $display("FAIL up_b step %0d: got %h expected %h", n, obs_b, exp_vec(mb, 1'b0, 1'b0));
            end
            tests++;
            if (obs_c !== exp_vec(mc, 1'b1, 1'b1)) begin
                fails++; $display("FAIL up_c step %0d: got %h expected %h", n, obs_c, exp_vec(mc, 1'b1, 1'b1));
            end
            if (n == 1000) begin
                tests++;
                if (ifa.bcd !== 12'h000 || ifa.wrap !== 1'b1) begin
                    fails++; $display("FAIL up_wrap_edge: got bcd %h wrap %b expected 000 1", ifa.bcd, ifa.wrap);
                end
            end
        end
        tests++;
        if (wraps != 1) begin
            fails++; $display("FAIL up_wrap_count: got %0d expected 1", wraps);
        end
    endtask

    task automatic test_count_down();
        drive_cycle(1'b0, 1'b1, 12'h123, 1'b0, 1'b0);
        tests++;
        if (ifa.bcd !== 12'h123) begin
            fails++; $display("FAIL down_load: got %h expected 123", ifa.bcd);
        end
        for (int n = 1; n <= 124; n++) begin
            drive_cycle(1'b0, 1'b0, 12'h0, 1'b1, 1'b0);
            tests++;
            if (obs_a !== exp_vec(ma, 1'b0, 1'b0)) begin
                fails++; $display("FAIL down_a step %0d: got %h expected %h", n, obs_a, exp_vec(ma, 1'b0, 1'b0));
            end
            tests++;
            if (obs_b !== exp_vec(mb, 1'b0, 1'b0)) begin
                fails++; $display("FAIL down_b step %0d: got %h expected %h", n, obs_b, exp_vec(mb, 1'b0, 1'b0));
            end
            tests++;
            if (obs_c !== exp_vec(mc, 1'b1, 1'b1)) begin
                fails++; $display("FAIL down_c step %0d: got %h expected %h", n, obs_c, exp_vec(mc, 1'b1, 1'b1));
            end
            if (n == 123) begin
                tests++;
                if (ifa.bcd !== 12'h000 || ifa.wrap !== 1'b0) begin
                    fails++; $display("FAIL down_zero: got bcd %h wrap %b expected 000 0", ifa.bcd, ifa.wrap);
                end
            end
            if (n == 124) begin
                tests++;
                if (ifa.bcd !== 12'h999 || ifa.wrap !== 1'b1) begin
                    fails++; $display("FAIL down_wrap: got bcd %h wrap %b expected 999 1", ifa.bcd, ifa.wrap);
                end
            end
        end
    endtask

    task automatic test_saturate();
        drive_cycle(1'b0, 1'b1, 12'h998, 1'b0, 1'b1);
        for (int n = 1; n <= 3; n++) begin
            drive_cycle(1'b0, 1'b0, 12'h0, 1'b1, 1'b1);
            tests++;
            if (ifb.bcd !== 12'h999 || ifb.sat !== (n >= 2) || ifb.wrap !== 1'b0) begin
                fails++; $display("FAIL sat_up %0d: got bcd %h sat %b wrap %b expected 999 %b 0",
                                  n, ifb.bcd, ifb.sat, ifb.wrap, (n >= 2));
            end
        end
        drive_cycle(1'b0, 1'b0, 12'h0, 1'b1, 1'b0);
        tests++;
        if (ifb.bcd !== 12'h998 || ifb.sat !== 1'b0) begin
            fails++; $display("FAIL sat_release: got bcd %h sat %b expected 998 0", ifb.bcd, ifb.sat);
        end
        tests++;
        if (obs_a !== exp_vec(ma, 1'b0, 1'b0)) begin
            fails++; $display("FAIL sat_wrapmode_a: got %h expected %h", obs_a, exp_vec(ma, 1'b0, 1'b0));
        end
    endtask

    task automatic test_clr_load();
        drive_cycle(1'b1, 1'b1, 12'h555, 1'b1, 1'b1);
        tests++;
        if (ifa.bcd !== 12'h000 || ifa.load_err !== 1'b0) begin
            fails++; $display("FAIL clr_priority: got bcd %h err %b expected 000 0", ifa.bcd, ifa.load_err);
        end
        drive_cycle(1'b0, 1'b1, 12'h1A3, 1'b1, 1'b1);
        tests++;
        if (ifa.bcd !== 12'h103 || ifa.load_err !== 1'b1) begin
            fails++; $display("FAIL load_bad_digit: got bcd %h err %b expected 103 1", ifa.bcd, ifa.load_err);
        end
        drive_cycle(1'b0, 1'b0, 12'h0, 1'b0, 1'b1);
        tests++;
        if (ifa.bcd !== 12'h103 || ifa.load_err !== 1'b0) begin
            fails++; $display("FAIL load_err_pulse: got bcd %h err %b expected 103 0", ifa.bcd, ifa.load_err);
        end
    endtask

    task automatic test_blank_inv();
        drive_cycle(1'b0, 1'b1, 12'h007, 1'b0, 1'b1);
        tests++;
        if (ifc.seg !== 21'b1111111_1111111_0001111) begin
            fails++; $display("FAIL blank_inv_007: got %b expected %b", ifc.seg, 21'b1111111_1111111_0001111);
        end
        drive_cycle(1'b0, 1'b1, 12'h405, 1'b0, 1'b1);
        tests++;
        if (ifc.seg !== {~7'b0110011, ~7'b1111110, ~7'b1011011}) begin
            fails++; $display("FAIL blank_inv_405: got %b expected %b", ifc.seg, {~7'b0110011, ~7'b1111110, ~7'b1011011});
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b0, 1'b1, 12'h455, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 12'h0, 1'b1, 1'b1);
        tests++;
        if (ifa.bcd !== 12'h456) begin
            fails++; $display("FAIL arst_pre: got %h expected 456", ifa.bcd);
        end
        #2;
        rstn = 1'b0;
        #1;
        ma = '0; mb = '0; mc = '0;
        tests++;
        if (ifa.bcd !== 12'h000 || ifb.bcd !== 12'h000 || ifc.bcd !== 12'h000) begin
            fails++; $display("FAIL arst_immediate: got %h %h %h expected 000", ifa.bcd, ifb.bcd, ifc.bcd);
        end
        #1;
        rstn = 1'b1;
        drive_cycle(1'b0, 1'b0, 12'h0, 1'b1, 1'b1);
        tests++;
        if (ifa.bcd !== 12'h001 || obs_a !== exp_vec(ma, 1'b0, 1'b0)) begin
            fails++; $display("FAIL arst_resume: got %h expected %h", obs_a, exp_vec(ma, 1'b0, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [11:0] lv;
        bit          c, l, e, u;
        for (int n = 0; n < 400; n++) begin
            c  = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 4) != 0);
            u  = $urandom_range(0, 1) == 1;
            lv = 12'($urandom);
            if ($urandom_range(0, 3) == 0) lv = u ? 12'h998 : 12'h001;
            drive_cycle(c, l, lv, e, u);
            tests++;
            if (obs_a !== exp_vec(ma, 1'b0, 1'b0)) begin
                fails++; $display("FAIL rand_a %0d: got %h expected %h", n, obs_a, exp_vec(ma, 1'b0, 1'b0));
            end
            tests++;
            if (obs_b !== exp_vec(mb, 1'b0, 1'b0)) begin
                fails++; $display("FAIL rand_b %0d: got %h expected %h", n, obs_b, exp_vec(mb, 1'b0, 1'b0));
            end
            tests++;
            if (obs_c !== exp_vec(mc, 1'b1, 1'b1)) begin
                fails++; $display("FAIL rand_c %0d: got %h expected %h", n, obs_c, exp_vec(mc, 1'b1, 1'b1));
            end
        end
    endtask

    initial begin
        ma = '0; mb = '0; mc = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_clr_load();
        test_blank_inv();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter_7seg.md
Name: bcd_updown_counter_7seg

Overview:
- Parametrised N-digit BCD counter with per-digit 7-segment outputs; successor to the fixed 3-digit up-only 0..999 counter.
- Adds up/down counting, synchronous parallel load, synchronous clear, wrap or saturate mode, terminal-count flags and optional leading-zero blanking.
- Sits between the board clock/enable logic and the display pins; all digits advance in the same cycle (no per-decade enable lag).

Parameters:
- NDIG, 3, number of BCD digits (1..8); digit 0 = least significant.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
- BLANK_LZ, 0, 1 = blank leading-zero digits (digit 0 never blanked).
- SEG_ACT_LOW, 0, 1 = invert all segment outputs (common-anode boards).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear to all zeros.
- load  in  1  synchronous parallel load.
- load_val  in  4*NDIG  BCD load value, digit i at [4i+3:4i].
- en  in  1  count enable, one step per cycle while high.
- up  in  1  1 = increment, 0 = decrement.
- bcd  out  4*NDIG  registered count.
- seg  out  7*NDIG  segments {a,b,c,d,e,f,g} per digit, digit i at [7i+6:7i], a is MSB.
- wrap  out  1  registered one-cycle pulse on wrap-around.
- sat  out  1  registered level, high while a saturated count is blocked.
- load_err  out  1  registered one-cycle pulse when a load digit was > 9.

Behaviour:
- Reset (rstn low, async): bcd = 0, wrap = 0, sat = 0, load_err = 0; seg shows "0" on digit 0 and "0" or blank on the others per BLANK_LZ.
- Priority per rising edge: clr > load > en. wrap, sat and load_err default to 0 each cycle unless set below.
- clr: bcd <= 0; en and load are ignored that cycle.
- load: each digit <= load_val digit if ≤ 9, else 0. load_err = 1 if any digit was > 9.
- en & up: add 1 with decimal carry. Digit i increments when all lower digits are 9; a digit at 9 that increments goes to 0.
- en & ~up: subtract 1 with decimal borrow. Digit i decrements when all lower digits are 0; a digit at 0 that decrements goes to 9.
- Upper limit is all-9s (10^NDIG − 1); lower limit is 0.
- SATURATE=0:
  - up at all-9s -> 0 and wrap = 1.
  - down at 0 -> all-9s and wrap = 1.
- SATURATE=1:
  - up at all-9s, or down at 0 -> bcd holds, sat = 1, wrap stays 0.
  - sat clears on the first cycle with no blocked step.
- en low with no clr/load: bcd holds and flags return to 0.
- Latency: bcd updates one clock after the sampled controls. seg is combinational from bcd, so it is valid in the same cycle as bcd.
- Segment map (SEG_ACT_LOW=0):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - blank=0000000; any illegal code (unreachable) = 1001111 ("E").
- BLANK_LZ=1: digit i (i > 0) is blank when it and every higher digit are 0.
- SEG_ACT_LOW=1: every seg bit, including blanks, is inverted.
- Reset asserted mid-count clears immediately regardless of clk; the first edge after rstn deasserts acts normally.

Decomposition:
- Package bcd7seg_pkg holds:
  - the SEG_* 7-bit constants (0-9, blank, E);
  - function bcd_to_seg(logic [3:0]) -> logic [6:0];
  - localparam-style helper for the digit width (4).
- One natural sub-module, bcd_digit: a single decade register.
  - Inputs: clk, rstn, clr, load, ld_val, step, up.
  - Outputs: q, at_max (q==9), at_min (q==0).
- The top generates NDIG instances and derives each digit's step from the AND-chain of lower at_max/at_min signals, plus the global limit detect.

Test Plan (NDIG=3 unless stated):
- Reset, then en=1, up=1 for 1000 cycles -> bcd runs 000..999, then 000; wrap pulses exactly once, on the 999->000 edge. seg digit 0 follows the map at every step.
- load 0x123, then en=1, up=0 for 124 cycles -> bcd reaches 000 after 123 steps and 999 on step 124, with wrap=1 for that cycle only.
- SATURATE=1: load 0x998, en=1, up=1 for 3 cycles -> 999, 999, 999 with sat=1 on cycles 2-3. Then up=0 -> 998 and sat=0.
- Simultaneous clr=1, load=1 (0x555), en=1 -> bcd=000 and load_err=0. Next cycle load 0x1A3 -> bcd=0x103, load_err=1 for one cycle.
- BLANK_LZ=1, SEG_ACT_LOW=1: load 0x007 -> seg digits 2 and 1 = 1111111 (blank, inverted), digit 0 = 0001111 ("7" inverted).
- Pulse rstn low between clk edges while counting at 0x456 -> bcd=000 immediately. Counting resumes at 001 on the first enabled edge after release.
